riscv_muldiv: RTL



---
 rtl/riscv_muldiv_pkg.sv | 40 ++++
 rtl/riscv_muldiv_if.sv | 28 ++
 rtl/riscv_muldiv_step.sv | 35 +++
 rtl/riscv_muldiv.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg: shared constants for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM state type, the nominal latency and
// small helpers that decode operand signedness from funct3.
package riscv_muldiv_pkg;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

  // Accept-to-response latency in cycles for a full-length operation.
  localparam int MULDIV_LATENCY = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
           (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) ||
           (op == MULDIV_OP_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// riscv_muldiv_if: request/response channels between the execute stage
// (master) and the multiply/divide unit (slave), plus the pipeline kill.
interface riscv_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             kill;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, kill, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/riscv_muldiv_step.sv
// riscv_muldiv_step: one combinational iteration of the unit's datapath.
// Multiply: {hi, lo} holds {partial product, remaining multiplier}; add the
// multiplicand into hi when lo[0] is set, then shift the pair right.
// Divide: {hi, lo} holds {partial remainder, remaining dividend/quotient};
// shift left, trial-subtract the divisor and shift in the quotient bit.
module riscv_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd,
  input  logic [2*XLEN-1:0] acc,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Single shift-add or restoring-divide step selected by the operation class.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shifted  = acc[2*XLEN-1:XLEN-1];
    diff     = shifted - {1'b0, opnd};
    acc_next = {sum, acc[XLEN-1:1]};
    if (is_div) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit (IDLE -> BUSY -> DONE).
// Operands are reduced to magnitudes on accept, 32 unsigned iterations run
// through riscv_muldiv_step, and a final fix-up cycle applies signs and picks
// the result word. Optional macro RV_MULDIV_EARLY_EXIT_EN lets divide-by-zero,
// signed overflow and multiply-by-zero skip the iterations.
module riscv_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          rst,
  riscv_muldiv_if.slave bus
);
  import riscv_muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_t     state;
  logic [CNT_W-1:0]  count;
  logic              fixup;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic [TAG_W-1:0]  resp_tag_q;

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic              in_div;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc_init;
  logic              early;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result;

  function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;

  // Decode request signedness, take magnitudes and pick the accumulator seed.
  always_comb begin
    a_s      = $signed(bus.req_a);
    b_s      = $signed(bus.req_b);
    in_div   = op_is_div(bus.req_op);
    a_neg    = op_a_signed(bus.req_op) && (a_s < 0);
    b_neg    = op_b_signed(bus.req_op) && (b_s < 0);
    a_mag    = a_neg ? -bus.req_a : bus.req_a;
    b_mag    = b_neg ? -bus.req_b : bus.req_b;
    acc_init = in_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    early    = 1'b0;
`ifdef RV_MULDIV_EARLY_EXIT_EN
    // Seed the accumulator with the value the iterations would have produced.
    if (in_div && (bus.req_b == '0)) begin
      early    = 1'b1;
      acc_init = {a_mag, {XLEN{1'b1}}};
    end else if (op_b_signed(bus.req_op) && in_div &&
                 (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1)) begin
      early    = 1'b1;
      acc_init = {{XLEN{1'b0}}, a_mag};
    end else if (!in_div && ((bus.req_a == '0) || (bus.req_b == '0))) begin
      early    = 1'b1;
      acc_init = '0;
    end
`endif
  end

  riscv_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_q[2]),
    .opnd     (opnd),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // Fix-up: apply result signs and select the architectural output word.
  always_comb begin
    prod_s = neg_wide(acc, neg_q);
    quo    = neg_word(acc[XLEN-1:0], neg_q && !div_zero);
    rem    = neg_word(acc[2*XLEN-1:XLEN], neg_r);
    case (op_q)
      MULDIV_OP_MUL:                                      result = prod_s[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:                      result = quo;
      default:                                            result = rem;
    endcase
  end

  // Control FSM with its operand/accumulator/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      count        <= '0;
      fixup        <= 1'b0;
      op_q         <= '0;
      tag_q        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      opnd         <= '0;
      acc          <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else if (bus.kill) begin
      state        <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      fixup        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            tag_q       <= bus.req_tag;
            opnd        <= in_div ? b_mag : a_mag;
            acc         <= acc_init;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            div_zero    <= in_div && (bus.req_b == '0);
            count       <= CNT_W'(XLEN - 1);
            fixup       <= early;
            state       <= ST_BUSY;
            req_ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (fixup) begin
            resp_data_q  <= result;
            resp_tag_q   <= tag_q;
            fixup        <= 1'b0;
            state        <= ST_DONE;
            resp_valid_q <= 1'b1;
          end else begin
            acc <= acc_next;
            if (count == '0) begin
              fixup <= 1'b1;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
